// File: rtl/gbuff_arbiter.sv
// Round-robin arbiter sharing one single-port global buffer among NUM_REQ requesters,
// with bounded locked bursts and a registered per-requester read-return strobe.
module gbuff_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int WORD_W    = 32,
  parameter int INDX_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [NUM_REQ*INDX_W-1:0] index,
  input  logic [NUM_REQ*WORD_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [WORD_W-1:0]         rdata,
  output logic                      gb_wr_en,
  output logic [INDX_W-1:0]         gb_index,
  output logic [WORD_W-1:0]         gb_data_in,
  input  logic [WORD_W-1:0]         gb_data_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [PTR_W-1:0]   last_gnt;
  logic [PTR_W-1:0]   owner;
  logic               locked;
  logic [CNT_W-1:0]   burst_cnt;

  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               any_gnt;
  logic               cont;
  logic [CNT_W-1:0]   next_cnt;
  logic [NUM_REQ-1:0] rvalid_next;

  // Grant selection: a live lock wins, otherwise scan from last_gnt+1 so the
  // previous winner (including a lapsed lock owner) is considered last.
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    cont    = 1'b0;
    if (rst) begin
      any_gnt = 1'b0;
    end else if (locked && req[owner]) begin
      gnt_idx = owner;
      any_gnt = 1'b1;
      cont    = 1'b1;
    end else begin
      // Walk from farthest to nearest so the nearest requester wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = PTR_W'((int'(last_gnt) + k) % NUM_REQ);
        if (req[cand]) begin
          gnt_idx = cand;
          any_gnt = 1'b1;
        end
      end
    end
  end

  // Buffer-side muxing and read-return / burst bookkeeping for the chosen requester.
  always_comb begin
    gnt         = '0;
    gb_wr_en    = 1'b0;
    gb_index    = '0;
    gb_data_in  = '0;
    rvalid_next = '0;
    next_cnt    = cont ? (burst_cnt + CNT_W'(1)) : CNT_W'(1);
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
      gb_wr_en     = wr[gnt_idx];
      gb_index     = INDX_W'(index >> (int'(gnt_idx) * INDX_W));
      gb_data_in   = WORD_W'(wdata >> (int'(gnt_idx) * WORD_W));
      if (!wr[gnt_idx]) begin
        rvalid_next[gnt_idx] = 1'b1;
      end
    end
  end

  assign rdata = gb_data_out;

  // Pointer, lock/burst state and the one-cycle-delayed read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid    <= '0;
      locked    <= 1'b0;
      owner     <= '0;
      burst_cnt <= '0;
      last_gnt  <= PTR_W'(NUM_REQ - 1);
    end else begin
      rvalid <= rvalid_next;
      if (any_gnt) begin
        last_gnt <= gnt_idx;
        if (lock[gnt_idx] && (next_cnt < CNT_W'(MAX_BURST))) begin
          locked    <= 1'b1;
          owner     <= gnt_idx;
          burst_cnt <= next_cnt;
        end else begin
          locked    <= 1'b0;
          burst_cnt <= '0;
        end
      end else begin
        locked    <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Bench for gbuff_arbiter: directed scenarios plus random traffic, all compared
// every cycle against a behavioural arbiter/buffer model.
module tb_gbuff_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int I  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N-1:0]   wr = '0;
  logic [N*I-1:0] index = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [W-1:0]   rdata;
  logic           gb_wr_en;
  logic [I-1:0]   gb_index;
  logic [W-1:0]   gb_data_in;
  logic [W-1:0]   gb_data_out = '0;

  logic [W-1:0]   buf_mem [256];
  logic [W-1:0]   gold    [256];

  int             vectors = 0;
  int             errors  = 0;

  int             m_ptr, m_owner, m_cnt, e_idx;
  bit             m_locked;
  logic [N-1:0]   m_rvalid;
  logic [W-1:0]   m_rdata;

  gbuff_arbiter #(.NUM_REQ(N), .WORD_W(W), .INDX_W(I), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wr(wr), .index(index),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_data_in(gb_data_in),
    .gb_data_out(gb_data_out)
  );

  always #5 clk = ~clk;

  // Single-port buffer with 1-cycle registered read.
  always @(posedge clk) begin
    if (gb_wr_en) buf_mem[gb_index] <= gb_data_in;
    gb_data_out <= buf_mem[gb_index];
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit req_bit(input int j);
    return ((req >> j) & 3'b001) != 3'b000;
  endfunction

  function automatic int pick();
    if (rst) return -1;
    if (m_locked && req_bit(m_owner)) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (req_bit((m_ptr + k) % N)) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic apply(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N-1:0] w, input logic [N*I-1:0] ix,
                       input logic [N*W-1:0] wd);
    logic [N-1:0] eg;
    logic         ew;
    logic [I-1:0] ei;
    logic [W-1:0] ed;
    @(negedge clk);
    rst = r; req = rq; lock = lk; wr = w; index = ix; wdata = wd;
    #1;
    e_idx = pick();
    eg = '0; ew = 1'b0; ei = '0; ed = '0;
    if (e_idx >= 0) begin
      eg = N'(1 << e_idx);
      ew = ((wr >> e_idx) & 3'b001) != 3'b000;
      ei = I'(index >> (e_idx * I));
      ed = W'(wdata >> (e_idx * W));
    end
    chk("gnt", 96'(gnt), 96'(eg));
    chk("gb_wr_en", 96'(gb_wr_en), 96'(ew));
    chk("gb_index", 96'(gb_index), 96'(ei));
    chk("gb_data_in", 96'(gb_data_in), 96'(ed));
    chk("rvalid", 96'(rvalid), 96'(m_rvalid));
    if (m_rvalid != '0) chk("rdata", 96'(rdata), 96'(m_rdata));
  endtask

  task automatic tick();
    int ix;
    int n;
    @(posedge clk);
    if (rst) begin
      m_ptr = N - 1; m_locked = 1'b0; m_cnt = 0; m_rvalid = '0;
    end else begin
      m_rvalid = '0;
      if (e_idx >= 0) begin
        ix = int'(I'(index >> (e_idx * I)));
        if (((wr >> e_idx) & 3'b001) == 3'b000) begin
          m_rvalid = N'(1 << e_idx);
          m_rdata  = gold[ix];
        end else begin
          gold[ix] = W'(wdata >> (e_idx * W));
        end
        m_ptr = e_idx;
        if (((lock >> e_idx) & 3'b001) != 3'b000) begin
          n = (m_locked && m_owner == e_idx) ? m_cnt + 1 : 1;
          if (n >= MB) begin
            m_locked = 1'b0; m_cnt = 0;
          end else begin
            m_locked = 1'b1; m_owner = e_idx; m_cnt = n;
          end
        end else begin
          m_locked = 1'b0; m_cnt = 0;
        end
      end else begin
        m_locked = 1'b0; m_cnt = 0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] eg;
    for (int a = 0; a < 256; a++) begin
      buf_mem[a] = '0;
      gold[a]    = '0;
    end
    m_ptr = N - 1; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    m_rvalid = '0; m_rdata = '0; e_idx = -1;

    // Reset held with all requesting: nothing granted.
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 3'b111, 3'b000, 3'b000, 24'h020100, '0);
      chk("t1_gnt", 96'(gnt), 96'(3'b000));
      chk("t1_wr_en", 96'(gb_wr_en), 96'(1'b0));
      chk("t1_rvalid", 96'(rvalid), 96'(3'b000));
      tick();
    end

    // Plain rotation of reads, starting at req0.
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 3'b111, 3'b000, 3'b000, 24'h020100, '0);
      eg = N'(1 << (k % 3));
      chk("t2_gnt", 96'(gnt), 96'(eg));
      eg = (k == 0) ? 3'b000 : N'(1 << ((k - 1) % 3));
      chk("t2_rvalid", 96'(rvalid), 96'(eg));
      tick();
    end

    // Write then read-back of the same index.
    apply(1'b0, 3'b001, 3'b000, 3'b001, 24'h000005, {64'h0, 32'hDEADBEEF});
    chk("t3_wr_en", 96'(gb_wr_en), 96'(1'b1));
    chk("t3_index", 96'(gb_index), 96'(8'd5));
    chk("t3_rvalid_prev", 96'(rvalid), 96'(3'b100));
    tick();
    apply(1'b0, 3'b001, 3'b000, 3'b000, 24'h000005, '0);
    chk("t3_rd_gnt", 96'(gnt), 96'(3'b001));
    tick();
    apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
    chk("t3_rvalid", 96'(rvalid), 96'(3'b001));
    chk("t3_rdata", 96'(rdata), 96'(32'hDEADBEEF));
    tick();

    // Locked burst capped at MB grants, then round-robin onward.
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 3'b111, 3'b010, 3'b000, 24'h030201, '0);
      eg = (k < 4) ? 3'b010 : ((k == 4) ? 3'b100 : 3'b001);
      chk("t4_gnt", 96'(gnt), 96'(eg));
      tick();
    end

    // Owner drops its request mid-burst: lock released in the same cycle.
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 3'b011, 3'b010, 3'b000, 24'h040404, '0);
      chk("t5_gnt_lock", 96'(gnt), 96'(3'b010));
      tick();
    end
    apply(1'b0, 3'b001, 3'b000, 3'b000, 24'h040404, '0);
    chk("t5_gnt_drop", 96'(gnt), 96'(3'b001));
    tick();

    // Reset during a burst with a read in flight.
    apply(1'b0, 3'b011, 3'b010, 3'b000, 24'h000600, '0);
    chk("t6_gnt_pre", 96'(gnt), 96'(3'b010));
    tick();
    apply(1'b1, 3'b011, 3'b010, 3'b000, 24'h000600, '0);
    chk("t6_gnt_rst", 96'(gnt), 96'(3'b000));
    chk("t6_rvalid_inflight", 96'(rvalid), 96'(3'b010));
    tick();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 3'b111, 3'b001, 3'b000, 24'h000600, '0);
      eg = (k < 4) ? 3'b001 : 3'b010;
      chk("t6_gnt", 96'(gnt), 96'(eg));
      if (k == 0) chk("t6_rvalid_dropped", 96'(rvalid), 96'(3'b000));
      tick();
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      apply(($urandom_range(0, 49) == 0), N'($urandom), N'($urandom), N'($urandom),
            {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))},
            {$urandom, $urandom, $urandom});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
